plants_sprite_blitter: RTL and testbench
========================================

# plants_sprite_blitter

Copies one 32x32 plant sprite frame from the plant sprite-sheet ROM into the frame buffer at a given screen position, skipping transparent pixels and clipping at the screen edges. It is the write-side counterpart of the sprite display path. The display path reads sprite pixels per DrawX/DrawY. This block writes palette indices into frame-buffer RAM, and the scan-out logic later reads and colours them. It is commanded by the game logic through a valid/ready handshake, one sprite per command.

## Interface
- FB_W, 640: frame-buffer width in pixels.
- FB_H, 480: frame-buffer height in pixels.
- FB_AW, 19: frame-buffer address width.
- ROM_LAT, 1: sprite ROM read latency in cycles (synchronous ROM).
- NUM_PLANTS, 5: number of valid plant rows in the 16-bit ROM address space.
- vga_clk  in  1: the single clock. All logic runs on the rising edge.
- reset  in  1: synchronous, active-high reset.
- cmd_valid  in  1: a command is presented.
- cmd_ready  out  1: the block accepts a command. High only in IDLE.
- cmd_plant  in  3: plant row index.
- cmd_anim  in  3: animation frame, 0..7.
- cmd_x  in  10: screen X of the sprite's top-left corner.
- cmd_y  in  10: screen Y of the sprite's top-left corner.
- rom_addr  out  16: sprite ROM read address.
- rom_q  in  7: palette index, valid ROM_LAT cycles after rom_addr.
- fb_we  out  1: frame-buffer write strobe.
- fb_addr  out  FB_AW: frame-buffer write address.
- fb_data  out  7: palette index to write.
- busy  out  1: high whenever the state is not IDLE.
- done  out  1: one-cycle pulse when a command completes.
- err_invalid  out  1: one-cycle pulse, coincident with done, for a rejected plant index.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - All cmd_* fields are registered at acceptance.
  - Inputs are ignored while busy.
- Accepted command with cmd_plant >= NUM_PLANTS:
  - IDLE goes straight to DONE.
  - No ROM reads and no writes occur.
  - err_invalid pulses together with done.
- Accepted valid command: IDLE goes to RUN.
- RUN behaviour:
  - Counters sx and sy each span 0..31, with sx as the inner loop.
  - One ROM address is issued per cycle, for 1024 cycles.
  - rom_addr = sx + sy*384 + 32*(anim+2) + 12288*plant. It is computed at 16 bits and never overflows for valid plants.
- Pipeline: (sx, sy) and an issue-valid flag are delayed ROM_LAT cycles to align with rom_q.
- Write condition: with dx = x+sx and dy = y+sy, computed at 11 bits, a pixel is written when all of the following hold:
  - aligned valid is set;
  - rom_q != TRANSPARENT_IDX (0);
  - dx < FB_W;
  - dy < FB_H.
- A written pixel is registered as fb_addr = dy*FB_W + dx and fb_data = rom_q.
- State sequencing:
  - After the last issue, RUN goes to DRAIN, which lasts ROM_LAT+1 cycles.
  - DRAIN goes to DONE, which lasts one cycle with done=1.
  - DONE goes to IDLE.
- Reset at any time has the following effect on the next edge:
  - The state becomes IDLE and the pipeline valids clear.
  - fb_we=0 and no done pulse is produced.
  - The aborted sprite is partially written, which is acceptable.
- Reset values of the outputs:
  - 0: fb_we, fb_addr, fb_data, rom_addr, busy, done, err_invalid.
  - 1: cmd_ready.

## Timing
- Acceptance at cycle T:
  - RUN covers T+1..T+1024.
  - rom_addr for pixel k is presented at T+1+k.
- The fb write for pixel k is asserted at T+1+k+ROM_LAT+1, so write latency is ROM_LAT+1 after the issue.
- done occurs at T+1024+ROM_LAT+2. For ROM_LAT=1 this is T+1027.
- cmd_ready rises at done+1.
- For a rejected command: done and err_invalid occur at T+1, and cmd_ready rises at T+2.
- At most one write per cycle, with no back-pressure from the frame buffer, which is a single-cycle write port.

## Structure
- Shared package plants_pkg, holding:
  - SHEET_W=384, SPRITE_DIM=32, ANIM_COL_BASE=2, PLANT_ROW_STRIDE=12288, TRANSPARENT_IDX=0;
  - the blitter state enum.
- One sub-module: plants_blit_delay, a parameterised ROM_LAT-deep shift register. It carries the valid bit and the 5-bit sx and sy to align with rom_q.

## Test plan
- Reset:
  - Hold reset for 3 cycles.
  - All outputs must be 0 and cmd_ready must be 1.
  - Hold cmd_valid during reset: no acceptance occurs.
- Full sprite, nonzero pixels:
  - Use a ROM model with rom_q = {addr[5:0], 1'b1} and command plant=0, anim=0, x=0, y=0.
  - The first rom_addr must be 64.
  - The first write must be fb_addr=0, fb_data=7'h01.
  - There must be exactly 1024 writes, the last at fb_addr=31*640+31=19871.
  - done must occur at T+1027.
- Transparency:
  - Use a ROM model that returns 0 on even addresses, with plant=2, anim=3, x=100, y=50.
  - Writes must occur only on odd addresses, 512 in total.
  - The first rom_addr must be 24576+160=24736.
- Clipping:
  - Use x=620, y=470 with a fully opaque ROM.
  - There must be exactly 20*10=200 writes, the last at fb_addr=479*640+639.
  - done must still occur at T+1027.
- Invalid plant:
  - Use plant=5.
  - done and err_invalid must pulse at T+1.
  - rom_addr must not change and there must be zero writes.
- Abort and back-to-back:
  - Assert reset at T+500: fb_we must be 0 the next cycle and no done must occur.
  - Then present two commands with cmd_valid held high: the second must be accepted exactly at done+1 of the first.

Source files
------------

// File: rtl/plants_pkg.sv
// ---------------------------------------------------------------
// plants_pkg : sprite-sheet geometry and blitter state encoding
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package plants_pkg;

  localparam int SHEET_W          = 384;
  localparam int SPRITE_DIM       = 32;
  localparam int ANIM_COL_BASE    = 2;
  localparam int PLANT_ROW_STRIDE = 12288;
  localparam int TRANSPARENT_IDX  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_e;

  // Top-left ROM address of one animation frame of one plant row.
  function automatic logic [15:0] sprite_base(input logic [2:0] plant, input logic [2:0] anim);
    return 16'(SPRITE_DIM * (int'(anim) + ANIM_COL_BASE) + PLANT_ROW_STRIDE * int'(plant));
  endfunction

endpackage

`default_nettype wire

// File: rtl/plants_blit_delay.sv
// ---------------------------------------------------------------
// plants_blit_delay : LAT-deep shift register aligning the issue
//                     valid and sprite coordinates with rom_q
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module plants_blit_delay #(
  parameter int LAT = 1,
  parameter int W   = 5
) (
  input  logic         vga_clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] sx_i,
  input  logic [W-1:0] sy_i,
  output logic         valid_o,
  output logic [W-1:0] sx_o,
  output logic [W-1:0] sy_o
);

  logic [LAT-1:0] valid_q;
  logic [W-1:0]   sx_q [LAT];
  logic [W-1:0]   sy_q [LAT];

  // Only the valid chain is reset; coordinates are don't-care without it.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
    sx_q[0] <= sx_i;
    sy_q[0] <= sy_i;
    for (int i = 1; i < LAT; i++) begin
      sx_q[i] <= sx_q[i-1];
      sy_q[i] <= sy_q[i-1];
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign sx_o    = sx_q[LAT-1];
  assign sy_o    = sy_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/plants_sprite_blitter.sv
// ---------------------------------------------------------------
// plants_sprite_blitter : copies one 32x32 plant sprite from the
//                         sheet ROM into the frame buffer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module plants_sprite_blitter
  import plants_pkg::*;
#(
  parameter int FB_W       = 640,
  parameter int FB_H       = 480,
  parameter int FB_AW      = 19,
  parameter int ROM_LAT    = 1,
  parameter int NUM_PLANTS = 5
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_plant,
  input  logic [2:0]       cmd_anim,
  input  logic [9:0]       cmd_x,
  input  logic [9:0]       cmd_y,
  output logic [15:0]      rom_addr,
  input  logic [6:0]       rom_q,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [6:0]       fb_data,
  output logic             busy,
  output logic             done,
  output logic             err_invalid
);

  localparam int         DRAIN_W = $clog2(ROM_LAT + 2);
  localparam logic [4:0] LAST    = 5'(SPRITE_DIM - 1);

  blit_state_e        state_q, state_d;
  logic [4:0]         sx_q, sx_d, sy_q, sy_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [15:0]        base_q, base_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               err_q, err_d;
  logic               issue_valid;

  logic               al_valid;
  logic [4:0]         al_sx, al_sy;
  logic [10:0]        dx, dy;
  logic               pix_we;
  logic [FB_AW-1:0]   pix_addr;

  logic               fb_we_q;
  logic [FB_AW-1:0]   fb_addr_q;
  logic [6:0]         fb_data_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      drain_q <= '0;
      base_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      drain_q <= drain_d;
      base_q  <= base_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    drain_d     = drain_q;
    base_d      = base_q;
    x_d         = x_q;
    y_d         = y_q;
    err_d       = err_q;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err_invalid = 1'b0;
    issue_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          x_d  = cmd_x;
          y_d  = cmd_y;
          sx_d = '0;
          sy_d = '0;
          // A rejected plant leaves base_q alone so rom_addr does not move.
          if (int'(cmd_plant) >= NUM_PLANTS) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            base_d  = sprite_base(cmd_plant, cmd_anim);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        issue_valid = 1'b1;
        sx_d        = sx_q + 5'd1;
        if (sx_q == LAST) begin
          sy_d = sy_q + 5'd1;
          if (sy_q == LAST) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_W'(ROM_LAT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        err_invalid = err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rom_addr = base_q + 16'(sx_q) + 16'(sy_q) * 16'(SHEET_W);

  plants_blit_delay #(
    .LAT (ROM_LAT),
    .W   (5)
  ) u_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .valid_i (issue_valid),
    .sx_i    (sx_q),
    .sy_i    (sy_q),
    .valid_o (al_valid),
    .sx_o    (al_sx),
    .sy_o    (al_sy)
  );

  // 11-bit sums so positions past the right/bottom edge compare correctly.
  assign dx       = 11'(x_q) + 11'(al_sx);
  assign dy       = 11'(y_q) + 11'(al_sy);
  assign pix_we   = al_valid && (rom_q != 7'(TRANSPARENT_IDX)) &&
                    (dx < 11'(FB_W)) && (dy < 11'(FB_H));
  assign pix_addr = FB_AW'(dy) * FB_AW'(FB_W) + FB_AW'(dx);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      fb_we_q <= pix_we;
      if (pix_we) begin
        fb_addr_q <= pix_addr;
        fb_data_q <= rom_q;
      end
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_plants_sprite_blitter.sv
// ---------------------------------------------------------------
// tb_plants_sprite_blitter : randomized self-checking bench with a
//                            pixel-list reference model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_plants_sprite_blitter;

  localparam int FB_W       = 640;
  localparam int FB_H       = 480;
  localparam int FB_AW      = 19;
  localparam int ROM_LAT    = 1;
  localparam int NUM_PLANTS = 5;

  logic             vga_clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_plant = '0;
  logic [2:0]       cmd_anim = '0;
  logic [9:0]       cmd_x = '0;
  logic [9:0]       cmd_y = '0;
  logic [15:0]      rom_addr;
  logic [6:0]       rom_q = '0;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [6:0]       fb_data;
  logic             busy;
  logic             done;
  logic             err_invalid;

  plants_sprite_blitter #(
    .FB_W(FB_W), .FB_H(FB_H), .FB_AW(FB_AW), .ROM_LAT(ROM_LAT), .NUM_PLANTS(NUM_PLANTS)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_plant(cmd_plant), .cmd_anim(cmd_anim), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rom_addr(rom_addr), .rom_q(rom_q), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .busy(busy), .done(done), .err_invalid(err_invalid)
  );

  always #5 vga_clk = ~vga_clk;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          rom_mode = 0;
  int unsigned rom_seed = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic logic [6:0] rom_fn(input int mode, input int unsigned seed, input int a);
    int unsigned h;
    case (mode)
      0: return {a[5:0], 1'b1};
      1: return a[0] ? 7'(a) : 7'd0;
      2: return 7'h33;
      default: begin
        h = (32'(a) * 32'd2654435761) ^ seed;
        h = h ^ (h >> 13);
        if (h[1:0] == 2'b00) return 7'd0;
        return 7'(h >> 5);
      end
    endcase
  endfunction

  // Synchronous sprite ROM, one cycle of latency.
  always @(posedge vga_clk) rom_q <= rom_fn(rom_mode, rom_seed, int'(rom_addr));

  typedef struct { int c; int a; int d; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  done_q[$];
  int  err_q[$];

  always @(negedge vga_clk) begin
    if (fb_we)       got_q.push_back(wr_t'{c: cyc, a: int'(fb_addr), d: int'(fb_data)});
    if (done)        done_q.push_back(cyc);
    if (err_invalid) err_q.push_back(cyc);
  end

  task automatic tick();
    @(negedge vga_clk);
    #1;
  endtask

  // Expected writes for a command accepted at cycle t, pixel by pixel in raster order.
  task automatic add_expected(input int plant, input int anim, input int x, input int y, input int t);
    int base;
    base = 32 * (anim + 2) + 12288 * plant;
    for (int k = 0; k < 1024; k++) begin
      int sx, sy, a, dx, dy;
      logic [6:0] v;
      sx = k % 32;
      sy = k / 32;
      a  = base + sx + sy * 384;
      v  = rom_fn(rom_mode, rom_seed, a);
      dx = x + sx;
      dy = y + sy;
      if (v != 7'd0 && dx < FB_W && dy < FB_H)
        exp_q.push_back(wr_t'{c: t + ROM_LAT + 2 + k, a: dy * FB_W + dx, d: int'(v)});
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i].c != exp_q[i].c || got_q[i].a != exp_q[i].a || got_q[i].d != exp_q[i].d)
        return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic string describe(input int d);
    string s;
    s = $sformatf("index %0d, got %0d writes, required %0d", d, got_q.size(), exp_q.size());
    if (d >= 0 && d < got_q.size() && d < exp_q.size())
      s = {s, $sformatf("; got cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                        got_q[d].c, got_q[d].a, got_q[d].d, exp_q[d].c, exp_q[d].a, exp_q[d].d)};
    return s;
  endfunction

  // Returns at cycle T+1 where T is the acceptance cycle (t=-1 if never accepted).
  task automatic send_cmd(input int plant, input int anim, input int x, input int y, output int t);
    t = -1;
    cmd_plant = 3'(plant);
    cmd_anim  = 3'(anim);
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin
        t = cyc;
        break;
      end
      tick();
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_q.size() > n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    cmd_plant = 3'd1;
    cmd_x     = 10'd7;
    cmd_valid = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({fb_we, fb_addr, fb_data, rom_addr, busy, done, err_invalid, cmd_ready} !==
          {1'b0, {FB_AW{1'b0}}, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: we=%b addr=%0d data=%0d rom=%0d busy=%b done=%b err=%b ready=%b, required all 0 and ready=1",
                 i, fb_we, fb_addr, fb_data, rom_addr, busy, done, err_invalid, cmd_ready);
      end
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_accept: busy=%b ready=%b, required busy=0 ready=1", busy, cmd_ready);
    end
  endtask

  task automatic test_full_sprite();
    int t, n0, ne0, d;
    bit ok;
    got_q.delete(); exp_q.delete();
    rom_mode = 0;
    n0 = done_q.size(); ne0 = err_q.size();
    send_cmd(0, 0, 0, 0, t);
    checks++;
    if (rom_addr !== 16'd64) begin
      failures++; $display("FAIL full_first_rom_addr: got %0d, required 64", rom_addr);
    end
    add_expected(0, 0, 0, 0, t);
    wait_done(n0, ok);
    checks++;
    if (got_q.size() !== 1024) begin
      failures++; $display("FAIL full_write_count: got %0d, required 1024", got_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[0].a !== 0 || got_q[0].d !== 1) begin
      failures++; $display("FAIL full_first_write: got %0d writes, first addr/data not 0/1 (required 0/1)", got_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[$].a !== 19871) begin
      failures++; $display("FAIL full_last_write: got %0d, required 19871", got_q.size() ? got_q[$].a : -1);
    end
    d = first_diff();
    checks++;
    if (d !== -1) begin
      failures++; $display("FAIL full_writes: %s", describe(d));
    end
    checks++;
    if (!ok || done_q[n0] !== t + 1027) begin
      failures++; $display("FAIL full_done_cycle: got %0d, required %0d", ok ? done_q[n0] : -1, t + 1027);
    end
    checks++;
    if (err_q.size() !== ne0) begin
      failures++; $display("FAIL full_no_err: got %0d err pulses, required 0", err_q.size() - ne0);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL full_ready_after_done: ready=%b busy=%b, required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_transparency();
    int t, n0, d;
    bit ok, odd;
    got_q.delete(); exp_q.delete();
    rom_mode = 1;
    n0 = done_q.size();
    send_cmd(2, 3, 100, 50, t);
    checks++;
    if (rom_addr !== 16'd24736) begin
      failures++; $display("FAIL transp_first_rom_addr: got %0d, required 24736", rom_addr);
    end
    add_expected(2, 3, 100, 50, t);
    wait_done(n0, ok);
    checks++;
    if (got_q.size() !== 512) begin
      failures++; $display("FAIL transp_write_count: got %0d, required 512", got_q.size());
    end
    odd = 1'b1;
    foreach (got_q[i]) if (got_q[i].d % 2 == 0) odd = 1'b0;
    checks++;
    if (odd !== 1'b1) begin
      failures++; $display("FAIL transp_odd_only: got an even-address pixel written, required none");
    end
    d = first_diff();
    checks++;
    if (d !== -1) begin
      failures++; $display("FAIL transp_writes: %s", describe(d));
    end
  endtask

  task automatic test_clipping();
    int t, n0, d;
    bit ok;
    got_q.delete(); exp_q.delete();
    rom_mode = 2;
    n0 = done_q.size();
    send_cmd(1, 5, 620, 470, t);
    add_expected(1, 5, 620, 470, t);
    wait_done(n0, ok);
    checks++;
    if (got_q.size() !== 200) begin
      failures++; $display("FAIL clip_write_count: got %0d, required 200", got_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[$].a !== 479 * 640 + 639) begin
      failures++; $display("FAIL clip_last_write: got %0d, required %0d", got_q.size() ? got_q[$].a : -1, 479 * 640 + 639);
    end
    d = first_diff();
    checks++;
    if (d !== -1) begin
      failures++; $display("FAIL clip_writes: %s", describe(d));
    end
    checks++;
    if (!ok || done_q[n0] !== t + 1027) begin
      failures++; $display("FAIL clip_done_cycle: got %0d, required %0d", ok ? done_q[n0] : -1, t + 1027);
    end
  endtask

  task automatic test_invalid();
    int t;
    logic [15:0] ra;
    got_q.delete();
    ra = rom_addr;
    send_cmd(5, 2, 10, 10, t);
    checks++;
    if (done !== 1'b1 || err_invalid !== 1'b1) begin
      failures++; $display("FAIL invalid_pulse_t1: done=%b err=%b, required 1/1", done, err_invalid);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err_invalid !== 1'b0) begin
      failures++; $display("FAIL invalid_ready_t2: ready=%b done=%b err=%b, required 1/0/0", cmd_ready, done, err_invalid);
    end
    repeat (5) tick();
    checks++;
    if (rom_addr !== ra || got_q.size() !== 0) begin
      failures++; $display("FAIL invalid_no_activity: rom_addr=%0d writes=%0d, required %0d/0", rom_addr, got_q.size(), ra);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      int t, n0, ne0, d, p, an, x, y, exp_done, exp_err;
      bit ok;
      got_q.delete(); exp_q.delete();
      rom_mode = 3;
      rom_seed = $urandom;
      p  = (n == 0) ? 7 : int'($urandom_range(0, 7));
      an = $urandom_range(0, 7);
      x  = $urandom_range(0, 1) ? $urandom_range(600, 1023) : $urandom_range(0, 600);
      y  = $urandom_range(0, 1) ? $urandom_range(450, 1023) : $urandom_range(0, 450);
      n0 = done_q.size(); ne0 = err_q.size();
      send_cmd(p, an, x, y, t);
      if (p < NUM_PLANTS) add_expected(p, an, x, y, t);
      exp_done = (p < NUM_PLANTS) ? t + 1027 : t + 1;
      exp_err  = (p < NUM_PLANTS) ? 0 : 1;
      wait_done(n0, ok);
      d = first_diff();
      checks++;
      if (d !== -1) begin
        failures++; $display("FAIL rand%0d_writes p=%0d a=%0d x=%0d y=%0d: %s", n, p, an, x, y, describe(d));
      end
      checks++;
      if (!ok || done_q[n0] !== exp_done) begin
        failures++; $display("FAIL rand%0d_done_cycle: got %0d, required %0d", n, ok ? done_q[n0] : -1, exp_done);
      end
      checks++;
      if (err_q.size() - ne0 !== exp_err) begin
        failures++; $display("FAIL rand%0d_err: got %0d pulses, required %0d", n, err_q.size() - ne0, exp_err);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int t, n0, d;
    got_q.delete(); exp_q.delete();
    rom_mode = 0;
    n0 = done_q.size();
    send_cmd(3, 1, 40, 30, t);
    add_expected(3, 1, 40, 30, t);
    while (cyc < t + 500) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_idle: fb_we=%b busy=%b, required 0/0", fb_we, busy);
    end
    repeat (1100) tick();
    checks++;
    if (done_q.size() !== n0) begin
      failures++; $display("FAIL abort_no_done: got %0d done pulses, required 0", done_q.size() - n0);
    end
    while (exp_q.size() > 0 && exp_q[$].c > t + 500) void'(exp_q.pop_back());
    d = first_diff();
    checks++;
    if (d !== -1) begin
      failures++; $display("FAIL abort_partial_writes: %s", describe(d));
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, n0, d, pa, aa, xa, ya, pb, ab, xb, yb;
    bit ok;
    got_q.delete(); exp_q.delete();
    rom_mode = 3;
    rom_seed = $urandom;
    pa = $urandom_range(0, 4); aa = $urandom_range(0, 7);
    xa = $urandom_range(0, 700); ya = $urandom_range(0, 500);
    pb = $urandom_range(0, 4); ab = $urandom_range(0, 7);
    xb = $urandom_range(0, 700); yb = $urandom_range(0, 500);
    n0 = done_q.size();
    t1 = -1; t2 = -1;
    cmd_plant = 3'(pa); cmd_anim = 3'(aa); cmd_x = 10'(xa); cmd_y = 10'(ya);
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && t1 < 0; i++) begin
      if (cmd_ready) t1 = cyc;
      else tick();
    end
    tick();
    cmd_plant = 3'(pb); cmd_anim = 3'(ab); cmd_x = 10'(xb); cmd_y = 10'(yb);
    for (int i = 0; i < 3000 && t2 < 0; i++) begin
      if (cmd_ready) t2 = cyc;
      else tick();
    end
    tick();
    cmd_valid = 1'b0;
    add_expected(pa, aa, xa, ya, t1);
    add_expected(pb, ab, xb, yb, t2);
    wait_done(n0 + 1, ok);
    checks++;
    if (t1 < 0 || t2 !== t1 + 1028) begin
      failures++; $display("FAIL b2b_second_accept: got cycle %0d, required %0d", t2, t1 + 1028);
    end
    checks++;
    if (!ok || done_q[n0] !== t1 + 1027 || done_q[n0+1] !== t2 + 1027) begin
      failures++; $display("FAIL b2b_done_cycles: got %0d done pulses, required at %0d and %0d",
                           done_q.size() - n0, t1 + 1027, t2 + 1027);
    end
    d = first_diff();
    checks++;
    if (d !== -1) begin
      failures++; $display("FAIL b2b_writes: %s", describe(d));
    end
  endtask

  initial begin
    test_reset();
    test_full_sprite();
    test_transparency();
    test_clipping();
    test_invalid();
    test_random();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
